// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, word-length codes and
// the expected-parity helper used by the receive shift register.
package uart_pkg;

    typedef enum logic [2:0] {
        RSR_IDLE   = 3'd0,
        RSR_START  = 3'd1,
        RSR_DATA   = 3'd2,
        RSR_PARITY = 3'd3,
        RSR_STOP   = 3'd4
    } rsr_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Parity bit the transmitter should have sent for this character.
    // Stick parity forces the bit to ~eps regardless of the data.
    function automatic logic expected_parity(input logic [7:0] data,
                                             input logic [1:0] wls,
                                             input logic       eps,
                                             input logic       sp);
        logic [7:0] mask;
        mask = 8'hFF;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        if (sp)
            return ~eps;
        else if (eps)
            return ^(data & mask);
        else
            return ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for an asynchronous input plus a 1->0 edge
// detector. Reused for the modem-status inputs, so it carries no UART framing.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_prev;

    // Shift the raw input through the synchroniser chain and keep the previous
    // synchronised value for edge detection; idle-high line resets to 1.
    // NOTE: every clocked assignment uses <= so all flops update from the
    // pre-edge values, giving a true shift chain instead of a single flop.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            sync_q   <= '1;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign rxd_fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/uart_rsr.sv
// UART receive shift register: finds the start bit on the synchronised line,
// samples each bit at mid-period using the oversampled baud tick, and reports
// the character with parity, framing and break qualifiers on a one-cycle strobe.
module uart_rsr
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       rxd,
    input  logic       baud_tick,
    input  logic       rx_en,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rsr_data,
    output logic       rx_done,
    output logic       frame_error,
    output logic       parity_error,
    output logic       break_det,
    output logic       rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] ST_IDLE   = RSR_IDLE;
    localparam logic [2:0] ST_START  = RSR_START;
    localparam logic [2:0] ST_DATA   = RSR_DATA;
    localparam logic [2:0] ST_PARITY = RSR_PARITY;
    localparam logic [2:0] ST_STOP   = RSR_STOP;

    logic          rxd_s;
    logic          rxd_fall;
    logic [2:0]    state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_bit;
    logic [1:0]    cfg_wls;
    logic          cfg_pen;
    logic          cfg_eps;
    logic          cfg_sp;
    logic          sample_tick;
    logic          last_data_bit;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .rxd     (rxd),
        .rxd_s   (rxd_s),
        .rxd_fall(rxd_fall)
    );

    // The start bit is checked half a bit in; every later bit a full bit on,
    // which lands each sample near the middle of its bit period.
    assign sample_tick   = baud_tick &&
                           (tick_cnt == ((state == ST_START) ? MID_TICK : LAST_TICK));
    assign last_data_bit = (bit_cnt == ({1'b0, cfg_wls} + 3'd4));
    assign rx_busy       = (state != ST_IDLE);

    // Frame sequencer: tick/bit counting, bit capture and result publication.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            par_bit      <= 1'b0;
            cfg_wls      <= WLS_5;
            cfg_pen      <= 1'b0;
            cfg_eps      <= 1'b0;
            cfg_sp       <= 1'b0;
            rsr_data     <= '0;
            rx_done      <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_done <= 1'b0;

            if (baud_tick && state != ST_IDLE)
                tick_cnt <= sample_tick ? '0 : tick_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    // Config is frozen here so writes mid-frame cannot
                    // change how the current character is decoded.
                    if (rxd_fall && rx_en) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        shift_q  <= '0;
                        par_bit  <= 1'b0;
                        cfg_wls  <= wls;
                        cfg_pen  <= pen;
                        cfg_eps  <= eps;
                        cfg_sp   <= sp;
                    end
                end
                ST_START: begin
                    // A line back high at mid start bit is a glitch.
                    if (sample_tick)
                        state <= rxd_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        shift_q[bit_cnt] <= rxd_s;
                        if (last_data_bit) begin
                            bit_cnt <= '0;
                            state   <= cfg_pen ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_tick) begin
                        par_bit <= rxd_s;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_tick) begin
                        rx_done      <= 1'b1;
                        rsr_data     <= shift_q;
                        frame_error  <= ~rxd_s;
                        parity_error <= cfg_pen &
                                        (par_bit != expected_parity(shift_q, cfg_wls,
                                                                    cfg_eps, cfg_sp));
                        break_det    <= (shift_q == 8'h00) & (~cfg_pen | ~par_bit) & ~rxd_s;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rsr.sv
// Self-checking bench for uart_rsr: directed frames from the test plan plus
// randomized frames (random config, data, parity, stop bit, gaps and mid-frame
// config/enable changes) compared against a bit-counting reference model.
module tb_uart_rsr;

    localparam int OVS = 16;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       rxd = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_en = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic [7:0] rsr_data;
    logic       rx_done;
    logic       frame_error;
    logic       parity_error;
    logic       break_det;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // {data, frame_error, parity_error, break_det} per rx_done strobe
    logic [10:0] rx_q[$];

    uart_rsr #(
        .OVERSAMPLE (OVS),
        .SYNC_STAGES(2)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .rxd         (rxd),
        .baud_tick   (baud_tick),
        .rx_en       (rx_en),
        .wls         (wls),
        .pen         (pen),
        .eps         (eps),
        .sp          (sp),
        .rsr_data    (rsr_data),
        .rx_done     (rx_done),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .break_det   (break_det),
        .rx_busy     (rx_busy)
    );

    initial forever #5 pclk = ~pclk;

    // Baud tick: one pclk pulse every 4 pclks.
    initial forever begin
        repeat (3) @(negedge pclk);
        baud_tick = 1'b1;
        @(negedge pclk);
        baud_tick = 1'b0;
    end

    // Capture every completed character.
    initial forever begin
        @(negedge pclk);
        if (rx_done === 1'b1)
            rx_q.push_back({rsr_data, frame_error, parity_error, break_det});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what the receiver must report for a frame on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input int nbits,
                                                input bit has_par, input bit eps_i,
                                                input bit sp_i, input bit pbit,
                                                input bit stopb);
        logic [7:0] v;
        int         ones;
        bit         exp_p;
        bit         pe;
        bit         fe;
        bit         bd;
        v    = d & 8'((1 << nbits) - 1);
        ones = $countones(v);
        if (sp_i)      exp_p = !eps_i;
        else if (eps_i) exp_p = (ones % 2 == 1);
        else           exp_p = (ones % 2 == 0);
        pe = has_par && (pbit != exp_p);
        fe = !stopb;
        bd = (v == 8'h00) && (!has_par || !pbit) && !stopb;
        return {v, fe, pe, bd};
    endfunction

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            while (baud_tick !== 1'b1) @(posedge pclk);
        end
        #1;
    endtask

    task automatic put_bit(input logic b);
        rxd = b;
        wait_ticks(OVS);
    endtask

    task automatic set_cfg(input logic [1:0] w, input bit p, input bit e, input bit s);
        wls   = w;
        pen   = p;
        eps   = e;
        sp    = s;
        rx_en = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input bit pbit, input bit stopb, input bit scramble);
        put_bit(1'b0);
        if (scramble) begin
            wls   = 2'($urandom);
            pen   = 1'($urandom);
            eps   = 1'($urandom);
            sp    = 1'($urandom);
            rx_en = 1'($urandom);
        end
        for (int i = 0; i < nbits; i++) put_bit(d[i]);
        if (has_par) put_bit(pbit);
        put_bit(stopb);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (4) @(negedge pclk);
        n_checks++;
        if ({rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0",
                     {rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy});
        end
        presetn = 1'b1;
        repeat (4) @(negedge pclk);
        n_checks++;
        if ({rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0",
                     {rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy});
        end
    endtask

    task automatic test_8n1();
        logic [10:0] exp;
        set_cfg(2'b11, 0, 0, 0);
        rx_q.delete();
        exp = model_frame(8'hA5, 8, 0, 0, 0, 0, 1);
        send_frame(8'hA5, 8, 0, 0, 1, 0);
        wait_ticks(2);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL 8n1_count: got %0d strobes expected 1", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] !== exp) begin
                n_fail++;
                $display("FAIL 8n1_result: got %h expected %h", rx_q[0], exp);
            end
        end
        n_checks++;
        if ({rsr_data, frame_error, parity_error, break_det} !== exp) begin
            n_fail++;
            $display("FAIL 8n1_hold: got %h expected %h",
                     {rsr_data, frame_error, parity_error, break_det}, exp);
        end
    endtask

    task automatic test_7e1();
        logic [10:0] exp;
        set_cfg(2'b10, 1, 1, 0);
        for (int pb = 1; pb >= 0; pb--) begin
            rx_q.delete();
            exp = model_frame(8'h41, 7, 1, 1, 0, pb[0], 1);
            send_frame(8'h41, 7, 1, pb[0], 1, 0);
            wait_ticks(2);
            n_checks++;
            if (rx_q.size() != 1) begin
                n_fail++;
                $display("FAIL 7e1_count(p=%0d): got %0d expected 1", pb, rx_q.size());
            end else begin
                n_checks++;
                if (rx_q[0] !== exp) begin
                    n_fail++;
                    $display("FAIL 7e1_result(p=%0d): got %h expected %h", pb, rx_q[0], exp);
                end
            end
        end
    endtask

    task automatic test_stick5();
        logic [10:0] exp;
        set_cfg(2'b00, 1, 0, 1);
        rx_q.delete();
        exp = model_frame(8'hFF, 5, 1, 0, 1, 1, 1);
        // Upper bits driven as 1 on the wire never reach rsr_data (only 5 sent).
        send_frame(8'h1F, 5, 1, 1, 1, 0);
        wait_ticks(2);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL stick5_count: got %0d expected 1", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] !== exp) begin
                n_fail++;
                $display("FAIL stick5_result: got %h expected %h", rx_q[0], exp);
            end
        end
    endtask

    task automatic test_false_start();
        set_cfg(2'b11, 0, 0, 0);
        rx_q.delete();
        rxd = 1'b0;
        wait_ticks(2);
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL false_start_busy: got %b expected 1", rx_busy);
        end
        wait_ticks(2);
        rxd = 1'b1;
        wait_ticks(20);
        n_checks++;
        if ({rx_busy, 8'(rx_q.size())} !== 9'h0) begin
            n_fail++;
            $display("FAIL false_start_idle: busy=%b strobes=%0d expected 0/0",
                     rx_busy, rx_q.size());
        end
    endtask

    task automatic test_break();
        logic [10:0] exp;
        set_cfg(2'b11, 0, 0, 0);
        rx_q.delete();
        exp = model_frame(8'h00, 8, 0, 0, 0, 0, 0);
        rxd = 1'b0;
        wait_ticks(2 * 10 * OVS);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d expected 1", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] !== exp) begin
                n_fail++;
                $display("FAIL break_result: got %h expected %h", rx_q[0], exp);
            end
        end
        rx_q.delete();
        rxd = 1'b1;
        wait_ticks(OVS);
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL break_retrigger: got %0d strobes expected 0", rx_q.size());
        end
        exp = model_frame(8'h5A, 8, 0, 0, 0, 0, 1);
        send_frame(8'h5A, 8, 0, 0, 1, 0);
        wait_ticks(2);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp) begin
            n_fail++;
            $display("FAIL break_recover: strobes=%0d got %h expected %h",
                     rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : 11'h0, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  d;
        logic [10:0] exp;
        d = 8'h55;
        set_cfg(2'b11, 0, 0, 0);
        rx_q.delete();
        put_bit(1'b0);
        for (int i = 0; i < 3; i++) put_bit(d[i]);
        rxd = d[3];
        wait_ticks(8);
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b expected 1", rx_busy);
        end
        @(negedge pclk);
        presetn = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {rsr_data, rx_done, frame_error, parity_error, break_det, rx_busy});
        end
        rxd = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        wait_ticks(20);
        n_checks++;
        if (rx_q.size() != 0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: strobes=%0d busy=%b expected 0/0",
                     rx_q.size(), rx_busy);
        end
        exp = model_frame(8'h3C, 8, 0, 0, 0, 0, 1);
        send_frame(8'h3C, 8, 0, 0, 1, 0);
        wait_ticks(2);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_next: strobes=%0d got %h expected %h",
                     rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : 11'h0, exp);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [1:0]  w;
        bit          p, e, s, pb, sb, scr;
        int          nb, gap;
        logic [10:0] exp;
        for (int k = 0; k < 40; k++) begin
            w   = 2'($urandom);
            p   = 1'($urandom);
            e   = 1'($urandom);
            s   = 1'($urandom);
            d   = 8'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            scr = 1'($urandom);
            gap = sb ? $urandom_range(0, 3) : $urandom_range(2, 4);
            nb  = int'(w) + 5;
            set_cfg(w, p, e, s);
            rx_q.delete();
            exp = model_frame(d, nb, p, e, s, pb, sb);
            send_frame(d, nb, p, pb, sb, scr);
            n_checks++;
            if (rx_q.size() != 1) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got %0d expected 1", k, rx_q.size());
            end else begin
                n_checks++;
                if (rx_q[0] !== exp) begin
                    n_fail++;
                    $display("FAIL random_result[%0d] wls=%0d pen=%0d eps=%0d sp=%0d: got %h expected %h",
                             k, w, p, e, s, rx_q[0], exp);
                end
            end
            wait_ticks(gap);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_stick5();
        test_false_start();
        test_break();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rsr.md
Name: uart_rsr

Overview:
- Receive shift register stage of the UART. Deserialises the asynchronous rxd line using the 16x oversampled baud tick.
- Checks parity and stop bit.
- Delivers each completed character as rsr_data with a one-cycle rx_done strobe, plus frame_error and parity_error qualifiers.
- Sits directly upstream of the RX FIFO / RHR buffer stage, which writes on rx_done.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; power of 2, minimum 8.
- SYNC_STAGES, 2, flip-flop stages in the rxd synchroniser; minimum 2.

Ports:
- pclk  input  1  system clock.
- presetn  input  1  synchronous active-low reset.
- rxd  input  1  asynchronous serial input; idle high.
- baud_tick  input  1  single-pclk pulse at OVERSAMPLE x baud rate.
- rx_en  input  1  receiver enable; 0 holds FSM in IDLE.
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- pen  input  1  parity enable.
- eps  input  1  even parity select.
- sp  input  1  stick parity.
- rsr_data  output  8  received character, LSB-aligned, unused MSBs zero.
- rx_done  output  1  one-cycle strobe: rsr_data and error flags are valid.
- frame_error  output  1  stop bit sampled 0.
- parity_error  output  1  parity mismatch (0 when pen=0).
- break_det  output  1  all data, parity and stop bits sampled 0.
- rx_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; rxd synchroniser flops 1; FSM IDLE; bit and tick counters 0. Reset is synchronous on presetn=0.
- Reset mid-frame aborts the frame; no rx_done is produced.
- rxd is passed through the SYNC_STAGES synchroniser. A falling edge (previous sync value 1, current 0) is detected on pclk, independent of baud_tick.
- FSM states: IDLE, START, DATA, PARITY, STOP. The tick counter advances only on baud_tick.
- IDLE: on falling edge with rx_en=1, latch wls/pen/eps/sp into frame config, clear tick counter, go to START. Config changes mid-frame do not affect the frame.
- START: at tick count OVERSAMPLE/2-1 (mid-bit), sample rxd.
  - Sample 0: go to DATA, clear counters.
  - Sample 1: false start; go to IDLE with no output.
- DATA: sample every OVERSAMPLE ticks (count OVERSAMPLE-1), shift bits in LSB first. After wls+5 bits, go to PARITY if pen=1, else STOP.
- PARITY: sample one bit. The expected parity bit depends on sp and eps:
  - sp=0, eps=1: even parity, expected = ^data.
  - sp=0, eps=0: odd parity, expected = ~^data.
  - sp=1: expected = ~eps.
  - parity_error = sample != expected.
- STOP: sample one stop bit only, whatever the transmit stop-bit setting.
  - Next pclk after the sampling tick: rx_done=1 for exactly one cycle.
  - rsr_data is updated, zero-extended above wls+5 bits.
  - frame_error = ~stop_sample.
  - break_det = data==0 & (parity sample==0 or pen=0) & stop_sample==0.
  - Then go to IDLE.
- rsr_data, frame_error, parity_error and break_det hold until the next rx_done.
- Back-to-back frames: a falling edge in the same cycle the FSM enters IDLE is accepted.
- A line held low after a frame error does not retrigger; a new 1->0 edge is required.
- rx_en deasserted mid-frame: the current frame completes; rx_en is only checked in IDLE.
- baud_tick coincident with reset: reset wins.
- Latency: rx_done asserts 1 pclk after the baud_tick on which the stop bit is sampled.

Decomposition:
- uart_pkg holds:
  - rsr_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - WLS_5/6/7/8 encodings.
  - Function computing expected parity from (data, wls, eps, sp).
- Sub-module uart_rx_sync: the SYNC_STAGES synchroniser plus falling-edge detect. Outputs rxd_s and rxd_fall. It is shared with the modem-status inputs later.

Test Plan:
- 8N1 (wls=11, pen=0), byte 0xA5 at 16 ticks/bit -> one rx_done, rsr_data=0xA5, frame_error=0, parity_error=0, break_det=0.
- 7E1 (wls=10, pen=1, eps=1), data 0x41 with parity bit 1 -> rsr_data=0x41, parity_error=1. Same frame with parity bit 0 -> parity_error=0.
- 5-bit stick parity (wls=00, pen=1, sp=1, eps=0), data 0x1F, parity bit 1 -> rsr_data=0x1F, upper bits 0, parity_error=0.
- rxd low for only 4 ticks then high -> false start; no rx_done, rx_busy returns to 0.
- rxd held 0 for 2 full frames -> exactly one rx_done, rsr_data=0x00, frame_error=1, break_det=1. No further rx_done until rxd rises then falls.
- presetn=0 during bit 3 of 0x55 -> outputs 0, FSM IDLE, no rx_done. Next clean frame 0x3C is received correctly.
